// File: rtl/pid_pkg.sv
// Shared types, widths and the signed saturation helper for the heading PID loop.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERR   = 3'd1,
        TERMS = 3'd2,
        SUM   = 3'd3,
        OUT   = 3'd4
    } pid_state_t;

    localparam int ERR_W   = 10;
    localparam int PID_W   = 15;
    localparam int SPD_W   = 12;
    localparam int INTEG_W = 16;

    // Clamp a sign-extended value into the signed range of a w-bit result; caller truncates.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] val, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

endpackage

// File: rtl/pid_integrator.sv
// Heading-error integrator with anti-windup hold on overflow; exposes the scaled I term.
module pid_integrator
    import pid_pkg::*;
#(
    parameter int I_SHIFT = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic signed [ERR_W-1:0]   err_in,
    output logic signed [INTEG_W-1:0] i_term
);

    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [INTEG_W:0]   sum;

    always_comb begin
        sum     = (INTEG_W + 1)'(integ_q) + (INTEG_W + 1)'(err_in);
        integ_d = integ_q;
        if (clr)
            integ_d = '0;
        // Top two bits disagree only when the 16-bit sum overflowed: keep the old value.
        else if (en && (sum[INTEG_W] == sum[INTEG_W-1]))
            integ_d = sum[INTEG_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            integ_q <= '0;
        else
            integ_q <= integ_d;
    end

    assign i_term = integ_q >>> I_SHIFT;

endmodule

// File: rtl/pid_ctrl.sv
// Heading-loop PID sequencer: one steering update per accepted heading sample.
// Optional derivative path enabled by defining PID_DTERM_EN.
module pid_ctrl
    import pid_pkg::*;
#(
`ifdef PID_DTERM_EN
    parameter int D_COEFF   = 5,
`endif
    parameter int P_COEFF   = 3,
    parameter int I_SHIFT   = 4,
    parameter int SPD_SHIFT = 3
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    hdng_vld,
    input  logic signed [11:0]      dsrd_hdng,
    input  logic signed [11:0]      actl_hdng,
    input  logic        [10:0]      frwrd_spd,
    output logic signed [ERR_W-1:0] err_sat,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    pid_rdy,
    output logic                    busy,
    output logic                    ovrrun
);

    localparam logic signed [13:0] P_K = 14'(P_COEFF);

    pid_state_t                state_q, state_d;
    logic signed [ERR_W-1:0]   err_sat_q, err_sat_d;
    logic signed [13:0]        p_q, p_d, d_q, d_d;
    logic signed [PID_W-1:0]   pid_q, pid_d;
    logic signed [SPD_W-1:0]   lft_q, lft_d, rght_q, rght_d;
    logic                      pid_rdy_q, pid_rdy_d;
    logic                      busy_q, busy_d;
    logic                      ovrrun_q, ovrrun_d;

    logic signed [INTEG_W-1:0] i_term;
    logic signed [11:0]        err_raw;
    logic signed [SPD_W-1:0]   corr;
    logic signed [12:0]        lft_raw, rght_raw;
    logic signed [13:0]        d_calc;

    assign err_raw  = actl_hdng - dsrd_hdng;
    assign corr     = SPD_W'(pid_q >>> SPD_SHIFT);
    assign lft_raw  = $signed({2'b00, frwrd_spd}) + 13'(corr);
    assign rght_raw = $signed({2'b00, frwrd_spd}) - 13'(corr);

`ifdef PID_DTERM_EN
    localparam logic signed [13:0] D_K = 14'(D_COEFF);

    logic signed [ERR_W-1:0] prev_err_q, prev_err_d;
    logic signed [10:0]      diff_raw;
    logic signed [7:0]       diff_sat;

    always_comb begin
        diff_raw = 11'(err_sat_q) - 11'(prev_err_q);
        diff_sat = 8'(sat_s(32'(diff_raw), 8));
        d_calc   = 14'(diff_sat) * D_K;
    end
`else
    assign d_calc = '0;
`endif

    pid_integrator #(
        .I_SHIFT (I_SHIFT)
    ) u_integ (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (moving && (state_q == TERMS)),
        .clr    (!moving),
        .err_in (err_sat_q),
        .i_term (i_term)
    );

    always_comb begin
        state_d   = state_q;
        err_sat_d = err_sat_q;
        p_d       = p_q;
        d_d       = d_q;
        pid_d     = pid_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        pid_rdy_d = 1'b0;
        ovrrun_d  = ovrrun_q | (hdng_vld && (state_q != IDLE));
`ifdef PID_DTERM_EN
        prev_err_d = prev_err_q;
`endif
        if (!moving) begin
            // Losing motion abandons the sample and flushes loop memory.
            state_d = IDLE;
            lft_d   = '0;
            rght_d  = '0;
`ifdef PID_DTERM_EN
            prev_err_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (hdng_vld) state_d = ERR;
                ERR: begin
                    err_sat_d = ERR_W'(sat_s(32'(err_raw), ERR_W));
                    state_d   = TERMS;
                end
                TERMS: begin
                    p_d = 14'(err_sat_q) * P_K;
                    d_d = d_calc;
`ifdef PID_DTERM_EN
                    prev_err_d = err_sat_q;
`endif
                    state_d = SUM;
                end
                SUM: begin
                    pid_d   = PID_W'(INTEG_W'(p_q) + i_term + INTEG_W'(d_q));
                    state_d = OUT;
                end
                OUT: begin
                    lft_d     = SPD_W'(sat_s(32'(lft_raw), SPD_W));
                    rght_d    = SPD_W'(sat_s(32'(rght_raw), SPD_W));
                    pid_rdy_d = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_sat_q <= '0;
            p_q       <= '0;
            d_q       <= '0;
            pid_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            pid_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            ovrrun_q  <= 1'b0;
`ifdef PID_DTERM_EN
            prev_err_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            err_sat_q <= err_sat_d;
            p_q       <= p_d;
            d_q       <= d_d;
            pid_q     <= pid_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            pid_rdy_q <= pid_rdy_d;
            busy_q    <= busy_d;
            ovrrun_q  <= ovrrun_d;
`ifdef PID_DTERM_EN
            prev_err_q <= prev_err_d;
`endif
        end
    end

    assign err_sat  = err_sat_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign pid_rdy  = pid_rdy_q;
    assign busy     = busy_q;
    assign ovrrun   = ovrrun_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl; expected values worked out by hand for both PID_DTERM_EN builds.
module tb_pid_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               moving = 1'b0;
    logic               hdng_vld = 1'b0;
    logic signed [11:0] dsrd_hdng = '0;
    logic signed [11:0] actl_hdng = '0;
    logic        [10:0] frwrd_spd = '0;
    logic signed [9:0]  err_sat;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               pid_rdy;
    logic               busy;
    logic               ovrrun;

    int checks = 0;
    int errors = 0;

`ifdef PID_DTERM_EN
    localparam int EXP_L80   = 592;
    localparam int EXP_R80   = 432;
    localparam int EXP_L511  = 786;
    localparam int EXP_R511  = 238;
    localparam int EXP_RSAT1 = 1773;
    localparam int EXP_L16   = 116;
    localparam int EXP_R16   = 84;
`else
    localparam int EXP_L80   = 542;
    localparam int EXP_R80   = 482;
    localparam int EXP_L511  = 707;
    localparam int EXP_R511  = 317;
    localparam int EXP_RSAT1 = 1852;
    localparam int EXP_L16   = 106;
    localparam int EXP_R16   = 94;
`endif

    always #5 clk = ~clk;

    pid_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .moving    (moving),
        .hdng_vld  (hdng_vld),
        .dsrd_hdng (dsrd_hdng),
        .actl_hdng (actl_hdng),
        .frwrd_spd (frwrd_spd),
        .err_sat   (err_sat),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .pid_rdy   (pid_rdy),
        .busy      (busy),
        .ovrrun    (ovrrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Pulse hdng_vld for one cycle and count negedges until pid_rdy; 0 means it never came.
    task automatic sample(input logic signed [11:0] d, input logic signed [11:0] a,
                          input logic [10:0] f, output int lat);
        dsrd_hdng = d;
        actl_hdng = a;
        frwrd_spd = f;
        hdng_vld  = 1'b1;
        lat       = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            hdng_vld = 1'b0;
            if (pid_rdy === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic clear_loop();
        moving = 1'b0;
        @(negedge clk);
        moving = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n_rdy;

        repeat (3) begin
            @(negedge clk);
            moving    = 1'($urandom);
            hdng_vld  = 1'($urandom);
            dsrd_hdng = 12'($urandom);
            actl_hdng = 12'($urandom);
            frwrd_spd = 11'($urandom);
        end
        chk("rst_err_sat", err_sat, 0);
        chk("rst_lft", lft_spd, 0);
        chk("rst_rght", rght_spd, 0);
        chk("rst_pid_rdy", pid_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovrrun", ovrrun, 0);

        hdng_vld = 1'b0;
        moving   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        moving = 1'b1;

        sample(12'sd0, 12'sd80, 11'd512, lat);
        chk("lat_basic", lat, 5);
        chk("err_basic", err_sat, 80);
        chk("lft_basic", lft_spd, EXP_L80);
        chk("rght_basic", rght_spd, EXP_R80);
        @(negedge clk);
        chk("rdy_pulse", pid_rdy, 0);
        chk("busy_idle", busy, 0);
        chk("lft_hold", lft_spd, EXP_L80);

        clear_loop();
        chk("lft_clear", lft_spd, 0);
        chk("rght_clear", rght_spd, 0);

        sample(12'sd0, 12'h7FF, 11'd512, lat);
        chk("err_pos_sat", err_sat, 511);
        chk("lft_pos_sat", lft_spd, EXP_L511);
        chk("rght_pos_sat", rght_spd, EXP_R511);

        clear_loop();
        sample(12'h7FF, 12'sd0, 11'd512, lat);
        chk("err_neg_sat", err_sat, -512);

        clear_loop();
        sample(12'sd1, 12'h800, 11'd512, lat);
        chk("err_wrap", err_sat, 511);

        clear_loop();
        sample(12'sd0, 12'h7FF, 11'd2047, lat);
        chk("lft_clamp1", lft_spd, 2047);
        chk("rght_clamp1", rght_spd, EXP_RSAT1);
        sample(12'sd0, 12'h7FF, 11'd2047, lat);
        chk("lft_clamp2", lft_spd, 2047);
        chk("rght_clamp2", rght_spd, 1848);
        chk("ovrrun_clean", ovrrun, 0);

        // Second pulse lands while the FSM is in TERMS.
        clear_loop();
        dsrd_hdng = 12'sd0;
        actl_hdng = 12'sd16;
        frwrd_spd = 11'd100;
        hdng_vld  = 1'b1;
        n_rdy     = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            hdng_vld = (k == 2);
            if (pid_rdy === 1'b1) n_rdy++;
        end
        chk("ovr_rdy_cnt", n_rdy, 1);
        chk("ovrrun_set", ovrrun, 1);
        chk("lft_ovr", lft_spd, EXP_L16);
        chk("rght_ovr", rght_spd, EXP_R16);

        // Drop moving while the FSM sits in TERMS.
        dsrd_hdng = 12'sd0;
        actl_hdng = 12'sd80;
        frwrd_spd = 11'd512;
        hdng_vld  = 1'b1;
        @(negedge clk);
        hdng_vld = 1'b0;
        chk("busy_err", busy, 1);
        @(negedge clk);
        moving = 1'b0;
        n_rdy  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            moving = 1'b1;
            if (pid_rdy === 1'b1) n_rdy++;
        end
        chk("abort_no_rdy", n_rdy, 0);
        chk("abort_lft", lft_spd, 0);
        chk("abort_rght", rght_spd, 0);
        chk("abort_busy", busy, 0);

        sample(12'sd0, 12'sd80, 11'd512, lat);
        chk("lat_after", lat, 5);
        chk("lft_after", lft_spd, EXP_L80);
        chk("rght_after", rght_spd, EXP_R80);
        chk("ovrrun_sticky", ovrrun, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
